// File: rtl/i2c_slave_fsm_if.sv
// Bus and local-side signals of the I2C slave endpoint.
// The slave modport faces the bus pads and the local register logic.
interface i2c_slave_fsm_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_out;
    logic       sda_select;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_out, sda_select, tx_load, rx_data, rx_valid, addr_match, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_out, sda_select, tx_load, rx_data, rx_valid, addr_match, busy
    );
endinterface

// File: rtl/i2c_slave_fsm.sv
// I2C slave endpoint: oversamples SCL/SDA on clk, matches a 7-bit address,
// receives write bytes and transmits read bytes supplied by local logic.
module i2c_slave_fsm #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'b1011010,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst_,
    i2c_slave_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_hist, sda_hist;
    logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det, bit_done;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d, shifted;
    logic [7:0] rx_data_q, rx_data_d;
    logic rw_q, rw_d, phase_q, phase_d, rx_pend_q, rx_pend_d;
    logic sda_out_q, sda_out_d, sel_q, sel_d, match_q, match_d, busy_q, busy_d;
    logic rx_valid_q, rx_valid_d, tx_load_q, tx_load_d;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign sda_rise  = sda_s & ~sda_hist;
    assign sda_fall  = ~sda_s & sda_hist;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign bit_done  = (cnt_q == 3'd7);
    assign shifted   = {sh_q[6:0], sda_s};

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            rx_pend_q  <= 1'b0;
            sda_out_q  <= 1'b1;
            sel_q      <= 1'b0;
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            rx_pend_q  <= rx_pend_d;
            sda_out_q  <= sda_out_d;
            sel_q      <= sel_d;
            match_q    <= match_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

    // phase_q marks the second half of a two-fall sequence: the ACK drive
    // in ADDR_ACK/RX_ACK, or a reloaded byte awaiting its MSB in TX_ACK.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        rx_pend_d  = rx_pend_q;
        sda_out_d  = sda_out_q;
        sel_d      = sel_q;
        match_d    = match_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (stop_det || start_det) begin
            state_d   = stop_det ? IDLE : ADDR;
            busy_d    = ~stop_det;
            cnt_d     = '0;
            sh_d      = '0;
            phase_d   = 1'b0;
            rx_pend_d = 1'b0;
            match_d   = 1'b0;
            sel_d     = 1'b0;
            sda_out_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + 3'd1;
                    if (bit_done) begin
                        rw_d    = shifted[0];
                        phase_d = 1'b0;
                        state_d = (shifted[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        phase_d   = 1'b1;
                        sel_d     = 1'b1;
                        sda_out_d = 1'b0;
                        match_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        cnt_d   = '0;
                        if (rw_q) begin
                            sh_d      = bus.tx_data;
                            tx_load_d = 1'b1;
                            sda_out_d = bus.tx_data[7];
                            sel_d     = ~bus.tx_data[7];
                            state_d   = TX;
                        end else begin
                            sel_d     = 1'b0;
                            sda_out_d = 1'b1;
                            state_d   = RX;
                        end
                    end
                end
                RX: if (scl_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + 3'd1;
                    if (bit_done) begin
                        rx_pend_d = 1'b1;
                        phase_d   = 1'b0;
                        state_d   = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (rx_pend_q) begin
                        rx_pend_d  = 1'b0;
                        rx_data_d  = sh_q;
                        rx_valid_d = 1'b1;
                    end
                    if (scl_fall) begin
                        phase_d   = ~phase_q;
                        sel_d     = ~phase_q;
                        sda_out_d = phase_q;
                        if (phase_q) state_d = RX;
                    end
                end
                TX: if (scl_fall) begin
                    if (bit_done) begin
                        sel_d     = 1'b0;
                        sda_out_d = 1'b1;
                        cnt_d     = '0;
                        phase_d   = 1'b0;
                        state_d   = TX_ACK;
                    end else begin
                        sh_d      = {sh_q[6:0], 1'b0};
                        sda_out_d = sh_q[6];
                        sel_d     = ~sh_q[6];
                        cnt_d     = cnt_q + 3'd1;
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            sh_d      = bus.tx_data;
                            tx_load_d = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && phase_q) begin
                        sda_out_d = sh_q[7];
                        sel_d     = ~sh_q[7];
                        cnt_d     = '0;
                        phase_d   = 1'b0;
                        state_d   = TX;
                    end
                end
                WAIT_STOP: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sda_out    = sda_out_q;
    assign bus.sda_select = sel_q;
    assign bus.tx_load    = tx_load_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.addr_match = match_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: a behavioural I2C master drives randomized
// transactions; expected bus bytes, ACKs and pulse counts come from a transaction model.
module tb_i2c_slave_fsm;
    localparam logic [6:0] SA = 7'h5A;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    i2c_slave_fsm_if bus ();

    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;
    logic [7:0] tx_vals [16];
    int unsigned txl_cnt = 0;
    int unsigned half = 5;
    logic hold_late = 1'b0;

    // Wired-AND bus: the slave can only pull SDA low.
    assign sda_line    = sda_m & ~(bus.sda_select & ~bus.sda_out);
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_line;
    assign bus.tx_data = tx_vals[txl_cnt[3:0]];

    i2c_slave_fsm #(.SLAVE_ADDR(SA), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus.slave)
    );

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned rxv_cnt = 0, coll_cnt = 0, hi_chg_cnt = 0, drv1_cnt = 0, sel_cnt = 0;
    logic [7:0]  last_rx = '0;
    logic        sel_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse/bus-rule monitor, sampled 1 time unit after each active edge.
    always begin
        @(posedge clk);
        #1;
        if (rst_) begin
            if (bus.rx_valid) begin
                rxv_cnt++;
                last_rx = bus.rx_data;
            end
            if (bus.tx_load) txl_cnt++;
            if (bus.rx_valid && bus.tx_load) coll_cnt++;
            if (bus.sda_select != sel_prev && scl_m) hi_chg_cnt++;
            if (bus.sda_select && bus.sda_out) drv1_cnt++;
            if (bus.sda_select) sel_cnt++;
        end
        sel_prev = bus.sda_select;
    end

    task automatic wait_half();
        repeat (half) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            wait_half();
            scl_m = 1'b1;
            wait_half();
        end
        sda_m = 1'b0;
        wait_half();
        scl_m = 1'b0;
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        if (hold_late) #1;
        sda_m = b;
        wait_half();
        scl_m = 1'b1;
        repeat (half - 1) @(negedge clk);
        seen = sda_line;
        @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        if (hold_late) #1;
        sda_m = 1'b0;
        wait_half();
        scl_m = 1'b1;
        wait_half();
        sda_m = 1'b1;
        wait_half();
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(nack, s);
    endtask

    task automatic do_write(input logic [6:0] a, input int unsigned n, input logic [7:0] d0);
        logic ack;
        logic [7:0] d, last;
        logic match;
        int unsigned rx0, sel0;
        match = (a == SA);
        rx0 = rxv_cnt;
        sel0 = sel_cnt;
        last = '0;
        i2c_start();
        check_val("busy_start", bus.busy, 1);
        send_byte({a, 1'b0}, ack);
        check_val("w_addr_ack", ack, match ? 0 : 1);
        for (int unsigned k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : 8'($urandom);
            send_byte(d, ack);
            check_val("w_data_ack", ack, match ? 0 : 1);
            last = d;
        end
        check_val("w_match", bus.addr_match, match);
        if (!match) check_val("nomatch_sel", sel_cnt - sel0, 0);
        i2c_stop();
        check_val("w_rx_cnt", rxv_cnt - rx0, match ? n : 0);
        if (match) check_val("w_rx_data", last_rx, last);
        check_val("busy_stop", bus.busy, 0);
        check_val("match_stop", bus.addr_match, 0);
    endtask

    task automatic do_read(input logic [6:0] a, input int unsigned n);
        logic ack;
        logic [7:0] d;
        logic match;
        int unsigned tl0, idx;
        match = (a == SA);
        tl0 = txl_cnt;
        i2c_start();
        send_byte({a, 1'b1}, ack);
        check_val("r_addr_ack", ack, match ? 0 : 1);
        for (int unsigned k = 0; k < n; k++) begin
            recv_byte(k == n - 1, d);
            idx = (tl0 + k) % 16;
            check_val("r_byte", d, match ? tx_vals[idx] : 8'hFF);
        end
        check_val("r_tx_loads", txl_cnt - tl0, match ? n : 0);
        check_val("r_release", bus.sda_select, 0);
        i2c_stop();
        check_val("r_busy_stop", bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack, s;
        logic [7:0] d;
        int unsigned rx0, sel0;
        for (int i = 0; i < 16; i++) tx_vals[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_match", bus.addr_match, 0);
        check_val("rst_sel", bus.sda_select, 0);
        check_val("rst_rxv", bus.rx_valid, 0);
        check_val("rst_txl", bus.tx_load, 0);
        check_val("rst_rxd", bus.rx_data, 0);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);

        // Directed write, non-matching write
        do_write(SA, 1, 8'hA5);
        do_write(7'h1E, 1, 8'h33);

        // Read two bytes, master ACK then NACK
        tx_vals[txl_cnt % 16]       = 8'h57;
        tx_vals[(txl_cnt + 1) % 16] = 8'hEA;
        do_read(SA, 2);

        // Repeated START cuts a partial write byte
        i2c_start();
        send_byte(8'hB4, ack);
        check_val("rs_addr_ack", ack, 0);
        rx0 = rxv_cnt;
        for (int i = 0; i < 4; i++) i2c_bit(1'($urandom), s);
        check_val("rs_match_before", bus.addr_match, 1);
        i2c_start();
        check_val("rs_match_clr", bus.addr_match, 0);
        check_val("rs_busy", bus.busy, 1);
        send_byte(8'hB5, ack);
        check_val("rs_new_ack", ack, 0);
        check_val("rs_match_again", bus.addr_match, 1);
        recv_byte(1'b1, d);
        check_val("rs_rd_byte", d, tx_vals[(txl_cnt + 15) % 16]);
        i2c_stop();
        check_val("rs_no_rx", rxv_cnt - rx0, 0);

        // Reset while the slave drives the address ACK
        half = 4;
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(i == 7 || i == 5 || i == 4 || i == 2, s);
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check_val("ack_driving", bus.sda_select, 1);
        #1 rst_ = 1'b0;
        #1;
        check_val("arst_sel", bus.sda_select, 0);
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_match", bus.addr_match, 0);
        check_val("arst_rxv", bus.rx_valid, 0);
        check_val("arst_txl", bus.tx_load, 0);
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        wait_half();
        scl_m = 1'b1;
        wait_half();
        scl_m = 1'b0;
        rx0 = rxv_cnt;
        sel0 = sel_cnt;
        send_byte(8'($urandom), ack);
        check_val("post_rst_ack", ack, 1);
        check_val("post_rst_busy", bus.busy, 0);
        check_val("post_rst_sel", sel_cnt - sel0, 0);
        i2c_stop();
        check_val("post_rst_rx", rxv_cnt - rx0, 0);
        do_write(SA, 1, 8'($urandom));

        // Exact 8x oversampling with late SDA changes after SCL falls
        half = 4;
        hold_late = 1'b1;
        do_write(SA, 3, 8'h7E);
        tx_vals[txl_cnt % 16] = 8'h81;
        do_read(SA, 2);
        hold_late = 1'b0;

        // Randomized transactions
        for (int it = 0; it < 20; it++) begin
            logic [6:0] a;
            half = $urandom_range(4, 7);
            hold_late = 1'($urandom);
            a = ($urandom_range(0, 3) != 0) ? SA : 7'($urandom);
            if ($urandom_range(0, 1) != 0) do_read(a, $urandom_range(1, 3));
            else do_write(a, $urandom_range(1, 3), 8'($urandom));
        end

        check_val("rxv_txl_overlap", coll_cnt, 0);
        check_val("sel_change_scl_high", hi_chg_cnt, 0);
        check_val("drive_one", drv1_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
